mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//  Sits directly downstream of the register file: consumes the RS/RT read
//  data, holds results in HI/LO for MFHI/MFLO, and reports busy/done to control.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are WIDTH bits each
// PORTS
//  clk_i       in   1      clock; all state changes on posedge
//  rst_i       in   1      reset, synchronous, active-high
//  start_i     in   1      launch operation op_i on rs_data_i/rt_data_i
//  op_i        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data_i   in   WIDTH  multiplicand / dividend (register file RS port)
//  rt_data_i   in   WIDTH  multiplier / divisor (register file RT port)
//  hi_we_i     in   1      MTHI write strobe
//  lo_we_i     in   1      MTLO write strobe
//  wdata_i     in   WIDTH  MTHI/MTLO data
//  busy_o      out  1      operation in flight
//  done_o      out  1      one-cycle pulse: HI/LO hold the new result
//  hi_o        out  WIDTH  HI register
//  lo_o        out  WIDTH  LO register
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=IDLE, busy_o=0, done_o=0, hi_o=lo_o=0.
//   Reset has priority over everything, including mid-operation; in-flight op discarded.
//  FSM: IDLE -> CALC (32 cycles, counter 0..31) -> FIX (1 cycle) -> IDLE.
//   busy_o = (state != IDLE), registered.
//  Edge E0, IDLE and start_i=1: latch op, |rs|, |rt|, sign bits (signed ops only);
//   clear accumulator; go to CALC. start_i while busy_o=1 is ignored.
//  CALC, edges E1..E32: one iteration per edge.
//   MUL: shift-add on 2*WIDTH product, unsigned magnitudes.
//   DIV: restoring shift-subtract; remainder in upper half, quotient in lower.
//  FIX, edge E33: signed MUL: negate product if signs differ.
//   Signed DIV: quotient negated if signs differ; remainder takes dividend sign.
//   Write HI/LO, done_o<=1, state<=IDLE.
//  done_o high exactly the cycle after E33, then low; busy_o high after E0..E33.
//  Results: MUL -> HI=product[63:32], LO=product[31:0].
//   DIV -> LO=quotient, HI=remainder.
//  Divide by zero (either DIV op): LO=32'hFFFF_FFFF, HI=rs_data as latched; same latency.
//  DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (no trap).
//  MTHI/MTLO: honoured only in IDLE; value visible the next cycle.
//   Ignored while busy_o=1.
//   If start_i and a write strobe occur together in IDLE, start wins and the write is dropped.
//   hi_we_i and lo_we_i together write wdata_i to both.
//  hi_o/lo_o keep old values throughout CALC; they change only at FIX, MT* or reset.
//  New start_i in the done_o cycle is accepted (back-to-back ops).
// STRUCTURE
//  Package mdu_pkg holds:
//   op encodings MDU_MULT/MULTU/DIV/DIVU, state encodings IDLE/CALC/FIX, WIDTH.
//  No sub-module required.
//   Optional combinational mdu_sign_fix (negation/sign select) may be split out.
//  Single always block per register group; iteration counter is 5 bits.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF:
//   -> done_o one cycle after E33, HI=0xFFFFFFFE, LO=0x00000001.
//  MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0*x -> HI=LO=0.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIVU 7/2 -> LO=3, HI=1.
//   DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  DIVU 100/0 -> LO=0xFFFFFFFF, HI=100, same latency, busy_o returns to 0.
//  Start MULTU, pulse start_i and lo_we_i at cycle 5:
//   -> ignored, result unchanged.
//   Assert rst_i at cycle 10 -> next cycle busy_o=0, HI=LO=0, no done_o pulse.
//  IDLE MTLO 0x1234 -> lo_o=0x1234 next cycle.
//   start_i+hi_we_i same cycle -> write dropped, op runs.
//   Back-to-back start in done_o cycle -> second done_o after 34 more edges.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package mdu_pkg;

  // Architectural operand width; HI and LO are each this wide.
  localparam int MDU_WIDTH = 32;

  // Operation encodings as presented on op_i.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // True for the two divide operations.
  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // True for the two operations that treat operands as two's complement.
  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final result correction: turns the unsigned-magnitude product or
// quotient/remainder pair into the architectural HI/LO values.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH-1:0] raw_i,       // product, or {remainder, quotient}
  input  logic               is_div_i,
  input  logic               is_signed_i,
  input  logic               rs_neg_i,    // dividend / multiplicand was negative
  input  logic               rt_neg_i,    // divisor / multiplier was negative
  input  logic               div_zero_i,  // divisor was zero
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic               signs_differ;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign signs_differ = is_signed_i && (rs_neg_i ^ rt_neg_i);

  // Select negated or plain result halves depending on operation and signs.
  always_comb begin
    // NOTE: every output gets a value before any branch so no path leaves it unassigned (which would infer a latch).
    hi_o    = '0;
    lo_o    = '0;
    product = signs_differ ? -raw_i : raw_i;
    quot    = raw_i[WIDTH-1:0];
    rem     = raw_i[2*WIDTH-1:WIDTH];
    if (!is_div_i) begin
      hi_o = product[2*WIDTH-1:WIDTH];
      lo_o = product[WIDTH-1:0];
    end else begin
      // With a zero divisor the restoring loop shifts the whole dividend
      // magnitude into the remainder, so the remainder path below already
      // reproduces the original rs value; only the quotient needs forcing.
      lo_o = div_zero_i ? '1 : (signs_differ ? -quot : quot);
      hi_o = (is_signed_i && rs_neg_i) ? -rem : rem;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One iteration per clock for WIDTH clocks, then one correction clock.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  mdu_op_e          op_e;
  logic             op_signed;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             launch;

  // Iteration datapath.
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, is_signed_q, rs_neg_q, rt_neg_q, div_zero_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;

  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign op_e      = mdu_op_e'(op_i);
  assign op_signed = op_is_signed(op_e);
  assign rs_mag    = (op_signed && rs_data_i[WIDTH-1]) ? -rs_data_i : rs_data_i;
  assign rt_mag    = (op_signed && rt_data_i[WIDTH-1]) ? -rt_data_i : rt_data_i;
  assign launch    = (state_q == IDLE) && start_i;

  // Next-state logic for the IDLE -> CALC -> FIX sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, iteration counter, busy and done flags.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == CALC) ? cnt_q + CNT_W'(1) : '0;
      busy_o  <= (state_d != IDLE);
      done_o  <= (state_q == FIX);
    end
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    acc_next  = acc_q;
    if (is_div_q) begin
      if (!div_trial[WIDTH+1]) acc_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                     acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_next = {mul_sum, acc_q[WIDTH-1:1]};
      else          acc_next = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Datapath registers: operand capture at launch, iterate during CALC.
  always_ff @(posedge clk_i) begin
    // NOTE: the datapath is not reset; launch always reloads it before any value is used.
    if (launch) begin
      is_div_q    <= op_is_div(op_e);
      is_signed_q <= op_signed;
      rs_neg_q    <= op_signed && rs_data_i[WIDTH-1];
      rt_neg_q    <= op_signed && rt_data_i[WIDTH-1];
      div_zero_q  <= (rt_data_i == '0);
      if (op_is_div(op_e)) begin
        acc_q  <= {{WIDTH{1'b0}}, rs_mag};
        opnd_q <= rt_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, rt_mag};
        opnd_q <= rs_mag;
      end
    end else if (state_q == CALC) begin
      acc_q <= acc_next;
    end
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw_i       (acc_q),
    .is_div_i    (is_div_q),
    .is_signed_i (is_signed_q),
    .rs_neg_i    (rs_neg_q),
    .rt_neg_i    (rt_neg_q),
    .div_zero_i  (div_zero_q),
    .hi_o        (fix_hi),
    .lo_o        (fix_lo)
  );

  // Architectural HI/LO: result write at FIX, MTHI/MTLO only in an idle cycle without a launch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (state_q == FIX) begin
      hi_o <= fix_hi;
      lo_o <= fix_lo;
    end else if ((state_q == IDLE) && !start_i) begin
      if (hi_we_i) hi_o <= wdata_i;
      if (lo_we_i) lo_o <= wdata_i;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] rs_data_i, rt_data_i, wdata_i;
  logic         hi_we_i, lo_we_i;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] m_hi, m_lo;   // model of architectural HI/LO

  always #5 clk_i = ~clk_i;

  mult_div_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .hi_we_i   (hi_we_i),
    .lo_we_i   (lo_we_i),
    .wdata_i   (wdata_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      default: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Launch one op, optionally disturb it mid-flight, and check result and timing.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int disturb, input logic we_at_start, input string tag);
    logic [W-1:0] eh, el;
    int           n;
    bit           seen;
    ref_op(op, a, b, eh, el);
    op_i      = op;
    rs_data_i = a;
    rt_data_i = b;
    start_i   = 1'b1;
    hi_we_i   = we_at_start;
    lo_we_i   = we_at_start;
    wdata_i   = 32'hDEAD_BEEF;
    tick();
    start_i   = 1'b0;
    hi_we_i   = 1'b0;
    lo_we_i   = 1'b0;
    rs_data_i = $urandom;   // operands must already be latched
    rt_data_i = $urandom;
    check({tag, " busy"}, busy_o, 1);
    n    = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      if (n == disturb) begin
        start_i   = 1'b1;
        op_i      = ~op;
        lo_we_i   = 1'b1;
        hi_we_i   = 1'b1;
        wdata_i   = 32'h5A5A_5A5A;
      end
      tick();
      n++;
      start_i = 1'b0;
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      if (n == 16) begin
        check({tag, " hold hi"}, hi_o, m_hi);
        check({tag, " hold lo"}, lo_o, m_lo);
      end
      seen = done_o;
    end
    check({tag, " latency"}, n, 33);
    check({tag, " hi"}, hi_o, eh);
    check({tag, " lo"}, lo_o, el);
    check({tag, " busy end"}, busy_o, 0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int dones;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    op_i      = 2'b00;
    rs_data_i = '0;
    rt_data_i = '0;
    hi_we_i   = 1'b0;
    lo_we_i   = 1'b0;
    wdata_i   = '0;
    m_hi      = '0;
    m_lo      = '0;
    tick();
    tick();
    rst_i = 1'b0;
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset hi", hi_o, 0);
    check("reset lo", lo_o, 0);

    // Directed corner cases, issued back to back from the done cycle.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, "multu max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         -1, 1'b0, "mult -3*5");
    run_op(2'b00, 32'd0,         32'h1234_5678, -1, 1'b0, "mult 0*x");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         -1, 1'b0, "div -7/2");
    run_op(2'b11, 32'd7,         32'd2,         -1, 1'b0, "divu 7/2");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, "div min/-1");
    run_op(2'b11, 32'd100,       32'd0,         -1, 1'b0, "divu 100/0");
    run_op(2'b10, 32'hFFFF_FF00, 32'd0,         -1, 1'b0, "div neg/0");

    // start_i and write strobes while busy are ignored.
    run_op(2'b01, 32'h0001_0003, 32'h0000_0707, 5, 1'b0, "busy ignore");

    // Reset mid-operation discards the op.
    op_i = 2'b01; rs_data_i = 32'hFFFF_FFFF; rt_data_i = 32'h3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("midreset busy", busy_o, 0);
    check("midreset done", done_o, 0);
    check("midreset hi", hi_o, 0);
    check("midreset lo", lo_o, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o) dones++;
    end
    check("midreset no done", dones, 0);

    // MTLO / MTHI in idle.
    wdata_i = 32'h1234; lo_we_i = 1'b1;
    tick();
    lo_we_i = 1'b0; m_lo = 32'h1234;
    check("mtlo lo", lo_o, m_lo);
    check("mtlo hi", hi_o, m_hi);
    wdata_i = 32'hCAFE_0001; hi_we_i = 1'b1;
    tick();
    hi_we_i = 1'b0; m_hi = 32'hCAFE_0001;
    check("mthi hi", hi_o, m_hi);
    check("mthi lo", lo_o, m_lo);
    wdata_i = 32'h0000_0077; hi_we_i = 1'b1; lo_we_i = 1'b1;
    tick();
    hi_we_i = 1'b0; lo_we_i = 1'b0; m_hi = 32'h77; m_lo = 32'h77;
    check("mt both hi", hi_o, m_hi);
    check("mt both lo", lo_o, m_lo);

    // Start together with write strobes: start wins.
    run_op(2'b11, 32'd1000, 32'd7, -1, 1'b1, "start+we");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, "b2b min*min");

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 17));
        2: ra = 32'($urandom_range(0, 300));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(rop, ra, rb, -1, 1'b0, $sformatf("rand%0d op%0d", i, rop));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
